// File: rtl/data_mem_lsu.sv
// rtl/data_mem_lsu.sv - RV64I load/store unit around a single-port 64-bit data RAM
//
// Purpose: byte/half/word/double loads and stores with byte-lane enables,
// sign/zero extension, misalignment and illegal-funct3 detection, and a
// fixed response latency of LATENCY cycles (1..4). One request per cycle,
// always ready; every accepted request produces exactly one response.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset (clears the response pipeline)
//   req_valid   request present this cycle
//   req_we      1 = store, 0 = load
//   req_funct3  RISC-V funct3 of the load/store
//   req_addr    byte address (wraps modulo DEPTH*8)
//   req_wdata   store data, right-aligned
//   rsp_valid   response for the request accepted LATENCY cycles earlier
//   rsp_rdata   extended load data; 0 for stores, faults and idle cycles
//   rsp_fault   response belongs to a misaligned or illegal access
module data_mem_lsu #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        rsp_fault
);

  logic [63:0] mem [DEPTH];

  logic [IDX_W-1:0] idx;
  logic [2:0]       off;
  logic [1:0]       sz;
  logic             misaligned;
  logic             illegal;
  logic             req_fault;
  logic [7:0]       size_mask;
  logic [7:0]       be;
  logic [63:0]      wshift;

  assign idx = req_addr[IDX_W+2:3];
  assign off = req_addr[2:0];
  assign sz  = req_funct3[1:0];

  // Address bits above the RAM are deliberately ignored (address wrap).
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[63:IDX_W+3];

  always_comb begin
    misaligned = 1'b0;
    size_mask  = 8'h01;
    case (sz)
      2'd0: begin misaligned = 1'b0;        size_mask = 8'h01; end
      2'd1: begin misaligned = off[0];      size_mask = 8'h03; end
      2'd2: begin misaligned = |off[1:0];   size_mask = 8'h0F; end
      default: begin misaligned = |off;     size_mask = 8'hFF; end
    endcase
  end

  assign illegal   = req_we ? req_funct3[2] : (req_funct3 == 3'b111);
  assign req_fault = illegal | misaligned;
  // Aligned accesses never carry lanes past bit 7, so the shift cannot truncate.
  assign be        = size_mask << off;
  assign wshift    = req_wdata << {off, 3'b000};

  // Store path: only the enabled lanes are written, faulted stores are dropped.
  always_ff @(posedge clk) begin
    if (req_valid && req_we && !req_fault) begin
      for (int b = 0; b < 8; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wshift[8*b +: 8];
      end
    end
  end

  // Raw read register kept free of reset so the RAM output register maps
  // onto block RAM; its value is masked downstream whenever it is not a
  // valid, non-faulted load.
  logic [63:0] s1_raw;
  always_ff @(posedge clk) begin
    if (req_valid && !req_we) s1_raw <= mem[idx];
  end

  logic       s1_valid;
  logic       s1_we;
  logic       s1_fault;
  logic [2:0] s1_off;
  logic [2:0] s1_funct3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_we     <= 1'b0;
      s1_fault  <= 1'b0;
      s1_off    <= 3'd0;
      s1_funct3 <= 3'd0;
    end else begin
      s1_valid <= req_valid;
      if (req_valid) begin
        s1_we     <= req_we;
        s1_fault  <= req_fault;
        s1_off    <= off;
        s1_funct3 <= req_funct3;
      end
    end
  end

  // Lane select and extension after stage 1.
  logic [63:0] shifted;
  logic [63:0] ext;
  logic        sx;
  logic        ext_valid;
  logic        ext_fault;
  logic [63:0] ext_data;

  assign shifted = s1_raw >> {s1_off, 3'b000};
  assign sx      = ~s1_funct3[2];

  always_comb begin
    ext = 64'd0;
    case (s1_funct3[1:0])
      2'd0:    ext = {{56{sx & shifted[7]}},  shifted[7:0]};
      2'd1:    ext = {{48{sx & shifted[15]}}, shifted[15:0]};
      2'd2:    ext = {{32{sx & shifted[31]}}, shifted[31:0]};
      default: ext = shifted;
    endcase
  end

  assign ext_valid = s1_valid;
  assign ext_fault = s1_valid & s1_fault;
  assign ext_data  = (s1_valid && !s1_we && !s1_fault) ? ext : 64'd0;

  generate
    if (LATENCY == 1) begin : g_direct
      assign rsp_valid = ext_valid;
      assign rsp_rdata = ext_data;
      assign rsp_fault = ext_fault;
    end else begin : g_pipe
      localparam int D = LATENCY - 1;
      logic [D-1:0] pv;
      logic [D-1:0] pf;
      logic [63:0]  pd [D];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pv <= '0;
          pf <= '0;
          for (int i = 0; i < D; i++) pd[i] <= 64'd0;
        end else begin
          pv[0] <= ext_valid;
          pf[0] <= ext_fault;
          pd[0] <= ext_data;
          for (int i = 1; i < D; i++) begin
            pv[i] <= pv[i-1];
            pf[i] <= pf[i-1];
            pd[i] <= pd[i-1];
          end
        end
      end

      assign rsp_valid = pv[D-1];
      assign rsp_rdata = pd[D-1];
      assign rsp_fault = pf[D-1];
    end
  endgenerate

`ifndef SYNTHESIS
  task automatic dump_mem(input int n);
    for (int i = 0; i < n && i < DEPTH; i++) begin
      $display("0x%0h: %016h %0d", i * 8, mem[i], mem[i]);
    end
  endtask
`endif

endmodule

// File: doc/data_mem_lsu.md
Name: data_mem_lsu

Overview:
- Parametrised successor of the core's single-port 64-bit data RAM.
- Adds RV64I sub-word access: LB/LH/LW/LD/LBU/LHU/LWU and SB/SH/SW/SD.
- Adds per-lane byte-enable writes, sign/zero extension, misalignment/illegal-access detection and a configurable read-pipeline latency.
- Sits between the EX/MEM pipeline register and MW_pipeline. One request per cycle, always ready, no backpressure.

Parameters:
- DEPTH, 1024: number of 64-bit words; power of two, ≥ 2.
- LATENCY, 1: cycles from request to response; legal range 1..4.
- IDX_W, $clog2(DEPTH): word-index width; derived, not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  request present this cycle
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RISC-V funct3 of the load/store
- req_addr  input  64  byte address
- req_wdata  input  64  store data, right-aligned (rs2)
- rsp_valid  output  1  response for the request accepted LATENCY cycles earlier
- rsp_rdata  output  64  extended load data; 0 for stores and faulted accesses
- rsp_fault  output  1  response belongs to a misaligned or illegal access

Behaviour:
- Reset (async assert, sync release): rsp_valid=0, rsp_rdata=0, rsp_fault=0.
  - All in-flight pipeline stages are cleared; responses in flight at reset are dropped, never emitted.
  - RAM contents are not reset.
- Word index = req_addr[IDX_W+2:3]. Upper address bits are ignored, so addresses wrap modulo DEPTH*8 bytes.
- Byte offset off = req_addr[2:0]. Size code = funct3[1:0]: 0 = byte, 1 = half, 2 = word, 3 = double.
- Illegal access:
  - load with funct3 = 3'b111;
  - store with funct3[2] = 1.
- Misaligned access: the address is not a multiple of the access size.
  - half: off[0] ≠ 0
  - word: off[1:0] ≠ 0
  - double: off ≠ 0
- Faulted access (illegal or misaligned):
  - store is suppressed (RAM unchanged);
  - load returns 0;
  - rsp_fault = 1 with its rsp_valid.
- Store:
  - Byte enables cover lanes off .. off+size-1.
  - req_wdata low bytes are shifted left by off*8 into those lanes.
  - Bytes outside the enables are untouched.
  - Write commits at the accepting edge.
- Load:
  - RAM read is synchronous at the accepting edge.
  - Selected lanes are shifted right by off*8.
  - Data is extended to 64 bits: sign-extended when funct3[2] = 0, zero-extended when funct3[2] = 1. LD ignores extension.
- Response pipeline:
  - Stage 1 registers raw RAM data, off, funct3, we and the fault bit.
  - Extension is applied combinationally after stage 1.
  - LATENCY-1 further register stages follow.
  - rsp_valid pulses exactly LATENCY cycles after the accepting edge.
- Every accepted request, load or store, produces exactly one response. Store responses carry rsp_rdata = 0.
- req_valid = 0: no RAM access and no response; the pipeline advances with bubbles.
- Back-to-back requests:
  - Store to X at cycle n, then load from X at n+1: the load returns the new data.
  - The single port never reads and writes in the same cycle.
- Outputs are registered after the extension stage, except when LATENCY = 1, where rsp_rdata is stage-1 data plus extension logic.
- No X propagation on rsp_rdata when rsp_valid = 0: it holds 0.
- Debug task dump_mem(n) prints the first n words as address/hex/decimal. Simulation only.

Test Plan:
1. LATENCY = 1: SD 0x8000_0000_0000_00FF to addr 0x10, then LD 0x10. Required: rsp_valid 1 cycle after the load, rsp_rdata = 0x8000_0000_0000_00FF, rsp_fault = 0.
2. Extension: after test 1, issue four loads. Required responses:
   - LB 0x10 → 0xFFFF_FFFF_FFFF_FFFF
   - LBU 0x10 → 0x0000_0000_0000_00FF
   - LW 0x14 → 0xFFFF_FFFF_8000_0000
   - LWU 0x14 → 0x0000_0000_8000_0000
3. Byte-enable writes: SD 0 to addr 0x20, then SB 0xAB to 0x23, then SH 0x1234 to 0x26. LD 0x20 must return 0x1234_0000_AB00_0000.
4. Faults: SW to 0x22 and LH from 0x21. Both respond with rsp_fault = 1 and rsp_rdata = 0, and the LD 0x20 value is unchanged. LWU-style store (funct3 = 3'b110, we = 1) also gives rsp_fault = 1.
5. LATENCY = 3, DEPTH = 16: ten back-to-back loads with bubbles interleaved. Required:
   - each rsp_valid exactly 3 cycles after its request, in order;
   - an address of 0x80 aliases word 0.
6. Reset mid-flight (LATENCY = 3): assert rst asynchronously one cycle after two loads. Required:
   - rsp_valid and rsp_rdata go 0 immediately;
   - no responses appear after release;
   - RAM contents persist, so a later load sees the earlier store data.
